// File: rtl/ay_bus_master.sv
// AY-3-8910 style bus master: runs one latch/write/read cycle per accepted request with fixed setup/strobe/hold timing.
// Read support is compiled in only when AY_BUS_MASTER_READ_EN is defined; otherwise type 10 is treated as reserved.
module ay_bus_master #(
    parameter int SETUP_CYC  = 3,
    parameter int STROBE_CYC = 14,
    parameter int HOLD_CYC   = 3
) (
    input  logic       fclk,
    input  logic       rst,
    input  logic       req,
    input  logic [1:0] req_type,
    input  logic       req_a8,
    input  logic       req_a9_n,
    input  logic [7:0] req_data,
    output logic       busy,
    output logic       ack,
    output logic [7:0] rd_data,
    output logic       aybdir,
    output logic       aybc2,
    output logic       aybc1,
    output logic       aya8,
    output logic       aya9_n,
    output logic [7:0] ayd_out,
    output logic       ayd_oe,
    input  logic [7:0] ayd_in
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [4:0] P_SETUP  = 5'(SETUP_CYC);
    localparam logic [4:0] P_STROBE = 5'(STROBE_CYC);
    localparam logic [4:0] P_HOLD   = 5'(HOLD_CYC);

    localparam logic [2:0] MODE_INACTIVE = 3'b010;
    localparam logic [2:0] MODE_LATCH    = 3'b111;
    localparam logic [2:0] MODE_WRITE    = 3'b110;
    localparam logic [2:0] MODE_READ     = 3'b011;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [4:0] r_cnt;
    logic [4:0] w_cnt_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_ack;
    logic       w_ack_nxt;

    logic [1:0] r_type;
    logic       r_a8;
    logic       r_a9_n;
    logic [7:0] r_data;

    logic       w_accept;
    logic       w_bus_type;
    logic       w_last;
    logic [2:0] w_mode;
    logic       w_oe;

    assign w_accept = (r_state == ST_IDLE) && !r_busy && req;
    assign w_last   = (r_cnt == 5'd1);

`ifdef AY_BUS_MASTER_READ_EN
    assign w_bus_type = (req_type != 2'b11);
`else
    assign w_bus_type = (req_type[1] == 1'b0);
`endif

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_ack   <= w_ack_nxt;
        end
    end

    // Reserved types never leave IDLE: one busy cycle that also carries the ack.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - 5'd1;
        w_busy_nxt  = r_busy;
        w_ack_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt  = r_cnt;
                w_busy_nxt = 1'b0;
                if (w_accept) begin
                    w_busy_nxt = 1'b1;
                    if (w_bus_type) begin
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = P_SETUP;
                    end else begin
                        w_ack_nxt = 1'b1;
                    end
                end
            end
            ST_SETUP: begin
                if (w_last) begin
                    w_state_nxt = ST_STROBE;
                    w_cnt_nxt   = P_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_last) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = P_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 5'd0;
                    w_busy_nxt  = 1'b0;
                    w_ack_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 5'd0;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Address lines and data only move on a real bus transaction, so IDLE keeps the last values.
    always_ff @(posedge fclk) begin
        if (rst) begin
            r_type <= 2'b00;
            r_a8   <= 1'b0;
            r_a9_n <= 1'b1;
            r_data <= 8'h00;
        end else if (w_accept && w_bus_type) begin
            r_type <= req_type;
            r_a8   <= req_a8;
            r_a9_n <= req_a9_n;
            r_data <= req_data;
        end
    end

`ifdef AY_BUS_MASTER_READ_EN
    logic [7:0] r_rd_data;

    always_ff @(posedge fclk) begin
        if (rst) begin
            r_rd_data <= 8'h00;
        end else if ((r_state == ST_STROBE) && w_last && (r_type == 2'b10)) begin
            r_rd_data <= ayd_in;
        end
    end

    assign rd_data = r_rd_data;
`else
    logic w_unused_ayd_in;

    assign w_unused_ayd_in = ^ayd_in;
    assign rd_data         = 8'h00;
`endif

    always_comb begin
        w_mode = MODE_INACTIVE;
        w_oe   = 1'b0;
        if (r_state != ST_IDLE) begin
            w_oe = (r_type[1] == 1'b0);
        end
        if (r_state == ST_STROBE) begin
            case (r_type)
                2'b00:   w_mode = MODE_LATCH;
                2'b01:   w_mode = MODE_WRITE;
`ifdef AY_BUS_MASTER_READ_EN
                2'b10:   w_mode = MODE_READ;
`endif
                default: w_mode = MODE_INACTIVE;
            endcase
        end
    end

    assign {aybdir, aybc2, aybc1} = w_mode;
    assign ayd_oe  = w_oe;
    assign ayd_out = r_data;
    assign aya8    = r_a8;
    assign aya9_n  = r_a9_n;
    assign busy    = r_busy;
    assign ack     = r_ack;

endmodule

// File: tb/tb_ay_bus_master.sv
// Directed bench for ay_bus_master: default-timing instance plus a 1/1/1 timing instance.
module tb_ay_bus_master;

    logic       fclk;
    logic       rst;
    logic       req;
    logic       req_f;
    logic [1:0] req_type;
    logic       req_a8;
    logic       req_a9_n;
    logic [7:0] req_data;
    logic [7:0] ayd_in;

    logic       busy, ack, aybdir, aybc2, aybc1, aya8, aya9_n, ayd_oe;
    logic [7:0] rd_data, ayd_out;

    logic       f_busy, f_ack, f_aybdir, f_aybc2, f_aybc1, f_aya8_unused, f_aya9_n_unused, f_ayd_oe;
    logic [7:0] f_rd_data_unused, f_ayd_out;

    ay_bus_master u_dut (
        .fclk(fclk), .rst(rst), .req(req), .req_type(req_type),
        .req_a8(req_a8), .req_a9_n(req_a9_n), .req_data(req_data),
        .busy(busy), .ack(ack), .rd_data(rd_data),
        .aybdir(aybdir), .aybc2(aybc2), .aybc1(aybc1),
        .aya8(aya8), .aya9_n(aya9_n), .ayd_out(ayd_out), .ayd_oe(ayd_oe),
        .ayd_in(ayd_in)
    );

    ay_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) u_fast (
        .fclk(fclk), .rst(rst), .req(req_f), .req_type(req_type),
        .req_a8(req_a8), .req_a9_n(req_a9_n), .req_data(req_data),
        .busy(f_busy), .ack(f_ack), .rd_data(f_rd_data_unused),
        .aybdir(f_aybdir), .aybc2(f_aybc2), .aybc1(f_aybc1),
        .aya8(f_aya8_unused), .aya9_n(f_aya9_n_unused), .ayd_out(f_ayd_out), .ayd_oe(f_ayd_oe),
        .ayd_in(ayd_in)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    // Observation mux: sel=1 watches the fast instance.
    logic       sel;
    logic [2:0] m_mode;
    logic       m_oe, m_ack, m_busy;
    logic [7:0] m_dout, m_rd;

    assign m_mode = sel ? {f_aybdir, f_aybc2, f_aybc1} : {aybdir, aybc2, aybc1};
    assign m_oe   = sel ? f_ayd_oe : ayd_oe;
    assign m_ack  = sel ? f_ack : ack;
    assign m_busy = sel ? f_busy : busy;
    assign m_dout = sel ? f_ayd_out : ayd_out;
    assign m_rd   = sel ? 8'h00 : rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    int ack_at, c111, c110, c011, c_act, c_oe, c_dbad, c_idle, n_cnt;
    logic busy1, busy_at_ack;
    logic [7:0] rd_seen;
    int ackpos [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fclk);
        #1;
    endtask

    // Issues one request, then samples every cycle (accept cycle = 0) until ack or budget.
    task automatic txn(input logic [1:0] t, input logic a8, input logic a9n, input logic [7:0] d);
        req_type = t;
        req_a8   = a8;
        req_a9_n = a9n;
        req_data = d;
        if (sel) req_f = 1'b1;
        else     req   = 1'b1;
        tick();
        req   = 1'b0;
        req_f = 1'b0;
        ack_at = 0; c111 = 0; c110 = 0; c011 = 0; c_act = 0; c_oe = 0; c_dbad = 0;
        busy1 = m_busy;
        busy_at_ack = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            if (m_mode == 3'b111) c111++;
            if (m_mode == 3'b110) c110++;
            if (m_mode == 3'b011) c011++;
            if (m_mode != 3'b010) c_act++;
            if (m_oe) begin
                c_oe++;
                if (m_dout != d) c_dbad++;
            end
            if (m_ack) begin
                ack_at = n;
                busy_at_ack = m_busy;
                break;
            end
            tick();
        end
        rd_seen = m_rd;
    endtask

    initial begin
        sel = 1'b0; rst = 1'b1; req = 1'b0; req_f = 1'b0;
        req_type = 2'b00; req_a8 = 1'b0; req_a9_n = 1'b1; req_data = 8'h00; ayd_in = 8'h00;
        tick();
        tick();

        check("rst_busy",   busy, 1'b0);
        check("rst_ack",    ack, 1'b0);
        check("rst_rd",     rd_data, 8'h00);
        check("rst_mode",   {aybdir, aybc2, aybc1}, 3'b010);
        check("rst_a8",     aya8, 1'b0);
        check("rst_a9n",    aya9_n, 1'b1);
        check("rst_dout",   ayd_out, 8'h00);
        check("rst_oe",     ayd_oe, 1'b0);

        // Latch, requested together with reset release.
        rst = 1'b0;
        txn(2'b00, 1'b1, 1'b0, 8'hFE);
        check("latch_busy_first", busy1, 1'b1);
        check("latch_ack_at",     ack_at, 21);
        check("latch_mode111",    c111, 14);
        check("latch_oe_cycles",  c_oe, 20);
        check("latch_dout_bad",   c_dbad, 0);
        check("latch_busy_ack",   busy_at_ack, 1'b0);
        check("latch_a8_hold",    aya8, 1'b1);
        check("latch_a9n_hold",   aya9_n, 1'b0);
        tick();
        check("latch_ack_pulse",  ack, 1'b0);
        tick();
        tick();
        check("idle_busy",        busy, 1'b0);
        check("idle_mode",        {aybdir, aybc2, aybc1}, 3'b010);

        // Write, then read.
        txn(2'b01, 1'b0, 1'b1, 8'h5A);
        check("wr_ack_at",    ack_at, 21);
        check("wr_mode110",   c110, 14);
        check("wr_oe_cycles", c_oe, 20);
        check("wr_dout_bad",  c_dbad, 0);
        ayd_in = 8'hC3;
        txn(2'b10, 1'b0, 1'b1, 8'h00);
`ifdef AY_BUS_MASTER_READ_EN
        check("rd_ack_at",    ack_at, 21);
        check("rd_mode011",   c011, 14);
        check("rd_oe_cycles", c_oe, 0);
        check("rd_data",      rd_seen, 8'hC3);
`else
        check("rd_as_rsv_ack_at", ack_at, 1);
        check("rd_as_rsv_active", c_act, 0);
        check("rd_as_rsv_oe",     c_oe, 0);
        check("rd_as_rsv_busy",   busy_at_ack, 1'b1);
        check("rd_as_rsv_data",   rd_seen, 8'h00);
`endif
        tick();

        // Reserved type.
        txn(2'b11, 1'b1, 1'b1, 8'hAA);
        check("rsv_ack_at", ack_at, 1);
        check("rsv_active", c_act, 0);
        check("rsv_oe",     c_oe, 0);
        check("rsv_busy",   busy_at_ack, 1'b1);
        check("rsv_a8",     aya8, 1'b0);
        check("rsv_a9n",    aya9_n, 1'b1);
        tick();
        check("rsv_ack_pulse", ack, 1'b0);
        check("rsv_busy_drop", busy, 1'b0);

        // Back-to-back: latch then two writes with req held high.
        req_type = 2'b00; req_a8 = 1'b1; req_a9_n = 1'b0; req_data = 8'hE1;
        req = 1'b1;
        tick();
        req_type = 2'b01; req_data = 8'h11;
        c111 = 0; c110 = 0; c_idle = 0; n_cnt = 0;
        for (int k = 0; k < 3; k++) ackpos[k] = 0;
        for (int n = 1; n <= 100; n++) begin
            if ({aybdir, aybc2, aybc1} == 3'b111) c111++;
            if ({aybdir, aybc2, aybc1} == 3'b110) c110++;
            if (!busy) c_idle++;
            if (ack) begin
                ackpos[n_cnt] = n;
                n_cnt++;
                if (n_cnt == 3) begin
                    req = 1'b0;
                    break;
                end
            end
            tick();
        end
        req = 1'b0;
        check("b2b_ack_count", n_cnt, 3);
        check("b2b_first_ack", ackpos[0], 21);
        check("b2b_gap_12",    ackpos[1] - ackpos[0], 21);
        check("b2b_gap_23",    ackpos[2] - ackpos[1], 21);
        check("b2b_mode111",   c111, 14);
        check("b2b_mode110",   c110, 28);
        check("b2b_idle_cyc",  c_idle, 3);
        tick();

        // Reset abort on STROBE cycle 5 of a write.
        req_type = 2'b01; req_a8 = 1'b1; req_a9_n = 1'b0; req_data = 8'h77;
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int n = 1; n < 8; n++) tick();
        check("abort_in_strobe", {aybdir, aybc2, aybc1}, 3'b110);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_mode", {aybdir, aybc2, aybc1}, 3'b010);
        check("abort_oe",   ayd_oe, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_ack",  ack, 1'b0);
        n_cnt = 0;
        for (int n = 0; n < 30; n++) begin
            if (ack) n_cnt++;
            tick();
        end
        check("abort_no_ack", n_cnt, 0);
        check("abort_rd",     rd_data, 8'h00);

        // Minimum timing instance.
        sel = 1'b1;
        txn(2'b00, 1'b1, 1'b0, 8'h3C);
        check("fast_ack_at",    ack_at, 4);
        check("fast_mode111",   c111, 1);
        check("fast_oe_cycles", c_oe, 3);
        check("fast_busy_ack",  busy_at_ack, 1'b0);
        sel = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
